// File: rtl/keypad_entry_tracker_pkg.sv
// Shared sizing and types for the keypad entry tracker: digit count, length code width
// and the overflow code.
package keypad_pkg;
  localparam int MAX_DIGITS   = 6;
  localparam int LEN_W        = 3;
  localparam int LEN_OVERFLOW = MAX_DIGITS + 1;

  typedef logic [LEN_W-1:0] len_t;
endpackage

// File: rtl/keypad_entry_tracker_if.sv
// Keypad-side inputs and progress/chip-select outputs of the entry tracker.
// The controller/front end uses master; the tracker uses slave.
interface keypad_entry_tracker_if;
  import keypad_pkg::*;

  logic                  is_pressed;
  logic                  is_star_pressed;
  logic                  clear;
  logic                  cs_en;
  len_t                  input_length;
  logic [MAX_DIGITS-1:0] input_cs;
  logic [MAX_DIGITS-1:0] password_led;

  modport master (
    output is_pressed, is_star_pressed, clear, cs_en,
    input  input_length, input_cs, password_led
  );

  modport slave (
    input  is_pressed, is_star_pressed, clear, cs_en,
    output input_length, input_cs, password_led
  );
endinterface

// File: rtl/keypad_entry_tracker_rise_detect.sv
// Rising-edge detector: a history flop plus AND. The history resets to 1 so a level
// already high when reset releases does not produce an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic hist_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_p0 <= 1'b1;
    else       hist_p0 <= level;
  end

  assign rise = level & ~hist_p0;
endmodule

// File: rtl/keypad_entry_tracker.sv
// Keypad digit length counter with one-hot cell chip-selects and thermometer progress LEDs.
// Optional macro KEYPAD_OVERFLOW_BLINK_EN blinks all LEDs while the entry has overflowed.
module keypad_entry_tracker
  import keypad_pkg::*;
#(
  parameter int BLINK_DIV = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_entry_tracker_if.slave bus
);
  localparam len_t LEN_MAX = len_t'(MAX_DIGITS);
  localparam len_t LEN_OVF = len_t'(LEN_OVERFLOW);

  if (BLINK_DIV < 1 || (2 ** LEN_W) < MAX_DIGITS + 2) begin : g_param_check
    $error("keypad_entry_tracker: BLINK_DIV must be >= 1 and 2**LEN_W >= MAX_DIGITS+2");
  end

  logic press;
  len_t len_p0;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .level (bus.is_pressed),
    .rise  (press)
  );

  // Clear beats star beats press; the count saturates at the overflow code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_p0 <= '0;
    end else if (bus.clear) begin
      len_p0 <= '0;
    end else if (!bus.is_star_pressed && press && (len_p0 != LEN_OVF)) begin
      len_p0 <= len_p0 + len_t'(1);
    end
  end

`ifdef KEYPAD_OVERFLOW_BLINK_EN
  logic [BLINK_DIV-1:0] presc_p0;
  logic                 blink_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_p0 <= '0;
      blink_p0 <= 1'b0;
    end else begin
      presc_p0 <= presc_p0 + BLINK_DIV'(1);
      if (&presc_p0) blink_p0 <= ~blink_p0;
    end
  end
`endif

  // Output decodes depend only on registered state (and the cs_en gate).
  always_comb begin
    bus.input_cs     = '0;
    bus.password_led = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      bus.input_cs[i]     = bus.cs_en && (len_p0 == len_t'(i));
      bus.password_led[i] = (len_p0 > len_t'(i));
    end
`ifdef KEYPAD_OVERFLOW_BLINK_EN
    if (len_p0 == LEN_OVF) bus.password_led = {MAX_DIGITS{blink_p0}};
`endif
  end

  assign bus.input_length = len_p0;

  logic unused_max;
  assign unused_max = (len_p0 == LEN_MAX);
endmodule

// File: tb/tb_keypad_entry_tracker.sv
// Scoreboard bench for keypad_entry_tracker: directed scenarios followed by random
// keypad activity, compared against a counting model of the entry rules.
module tb_keypad_entry_tracker;
  localparam int MAXD = 6;
  localparam int OVF  = MAXD + 1;
  localparam int BDIV = 2;

  typedef struct {
    int len;
    int cs;
    int led;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  keypad_entry_tracker_if bus ();

  keypad_entry_tracker #(.BLINK_DIV(BDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: digits typed, previous key level, clock edges since reset.
  int m_cnt;
  bit m_prev;
  int m_edges;

  task automatic model_reset();
    m_cnt   = 0;
    m_prev  = 1'b1;
    m_edges = 0;
  endtask

  task automatic model_edge(input logic p, input logic s, input logic c);
    bit is_new;
    is_new = p && !m_prev;
    m_prev = p;
    if (c)                          m_cnt = 0;
    else if (s)                     m_cnt = m_cnt;
    else if (is_new && m_cnt < OVF) m_cnt = m_cnt + 1;
    m_edges++;
  endtask

  function automatic exp_t model_out(input logic e);
    exp_t x;
    x.len = m_cnt;
    x.cs  = (e && m_cnt < MAXD) ? (1 << m_cnt) : 0;
    if (m_cnt >= OVF) begin
`ifdef KEYPAD_OVERFLOW_BLINK_EN
      x.led = (((m_edges >> BDIV) & 1) != 0) ? (1 << MAXD) - 1 : 0;
`else
      x.led = (1 << MAXD) - 1;
`endif
    end else begin
      x.led = (1 << m_cnt) - 1;
    end
    return x;
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Called just after a clock edge: apply inputs, queue expected outputs for this
  // cycle, then advance DUT and model together at the next edge.
  task automatic step(input logic p, input logic s, input logic c, input logic e);
    bus.is_pressed      = p;
    bus.is_star_pressed = s;
    bus.clear           = c;
    bus.cs_en           = e;
    exp_q.push_back(model_out(e));
    @(posedge clk);
    model_edge(p, s, c);
    #1;
  endtask

  task automatic pulses(input int n, input logic s);
    for (int k = 0; k < n; k++) begin
      step(1, s, 0, 1);
      step(1, s, 0, 1);
      step(0, s, 0, 1);
      step(0, s, 0, 1);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("input_length", int'(bus.input_length), x.len);
        check("input_cs",     int'(bus.input_cs),     x.cs);
        check("password_led", int'(bus.password_led), x.led);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    reset               = 1'b1;
    bus.is_pressed      = 1'b1;
    bus.is_star_pressed = 1'b0;
    bus.clear           = 1'b0;
    bus.cs_en           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_len", int'(bus.input_length), 0);
    check("reset_led", int'(bus.password_led), 0);
    reset = 1'b0;
    model_reset();

    // Key held across reset release is not counted.
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    pulses(4, 0);
    pulses(8, 0);

    // Star freezes the count at 3.
    step(0, 0, 1, 1);
    pulses(3, 0);
    pulses(2, 1);
    pulses(1, 0);

    // Clear coincident with a press edge at 5; the held key is not counted later.
    pulses(1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    // Chip-select gating at length 2.
    pulses(2, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Asynchronous reset mid-cycle at length 5.
    pulses(3, 0);
    check("pre_reset_len", int'(bus.input_length), 5);
    #2 reset = 1'b1;
    #1;
    check("async_reset_len", int'(bus.input_length), 0);
    check("async_reset_led", int'(bus.password_led), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(0, 0, 0, 1);

    // Random keypad activity.
    p = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) p = ~p;
      step(p, ($urandom_range(0, 15) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 7) != 0));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_entry_tracker.md
Name: keypad_entry_tracker

Overview:
- Tracks how many keypad digits the user has entered for the current password word.
- Generates the one-hot write chip-selects for the 6-cell input register array.
- Drives the 6 password-progress LEDs.
- Sits between the keypad front end and the comparator / register arrays of the safe controller. It combines three functions: a length counter, a chip-select decoder and an LED manager.

Parameters:
- MAX_DIGITS, 6, number of digit cells and LEDs; the length code MAX_DIGITS+1 means overflow.
- LEN_W, 3, width of the length code; must satisfy 2**LEN_W >= MAX_DIGITS+2.
- BLINK_DIV, 24, overflow blink half-period is 2**BLINK_DIV clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- is_pressed  input  1  level, high while any keypad key except * is held (synchronous to clk).
- is_star_pressed  input  1  level, high while * is held (synchronous to clk).
- clear  input  1  synchronous clear of the length count (driven by the controller's clear_input).
- cs_en  input  1  global enable for the chip-select outputs.
- input_length  output  LEN_W  digits entered: 0..MAX_DIGITS, or MAX_DIGITS+1 for overflow.
- input_cs  output  MAX_DIGITS  one-hot write select for the next digit cell.
- password_led  output  MAX_DIGITS  progress LEDs.

Behaviour:
- Reset (asynchronous, active-high):
  - input_length = 0.
  - Edge-detect history flop = 1, so a key already held when reset releases is not counted.
  - Blink state = 0.
- Press event: is_pressed = 1 at a clk edge while the history flop = 0. The history flop samples is_pressed every cycle.
- Count update at the same clk edge as the press event; 1-cycle latency, so the new value is visible after that edge.
- Priority, highest first: reset > clear > is_star_pressed > press event.
  - clear = 1: input_length becomes 0. A coincident press event is discarded and is not counted later.
  - is_star_pressed = 1: count frozen and press events ignored. The * key never changes the count; clearing is the controller's job via clear.
  - Otherwise a press event increments input_length.
- Saturation: from MAX_DIGITS a press event moves input_length to MAX_DIGITS+1 (overflow). It stays there until clear or reset and never wraps to 0.
- input_cs (combinational): input_cs[i] = cs_en & (input_length == i) for i = 0..MAX_DIGITS-1.
  - With length MAX_DIGITS or overflow, input_cs is all zero.
  - With cs_en = 0, input_cs is all zero.
  - The chip-select for the digit just typed is therefore the one that was active before the increment. Its falling edge, as input_length advances, is the write strobe seen by the data cell.
- password_led (combinational, thermometer code): password_led[i] = (input_length > i).
  - Length 0: all off. Length 4: 4'b1111 in the low bits (6'b001111).
  - Overflow: all ones.
- All outputs are glitch-free registered-state decodes; no combinational path from is_pressed to any output.

Optional Feature:
- Macro: KEYPAD_OVERFLOW_BLINK_EN.
- Defined: a free-running BLINK_DIV-bit prescaler toggles a blink flop. While input_length == MAX_DIGITS+1, password_led = {MAX_DIGITS{blink}}. The prescaler and blink flop reset to 0.
- Not defined: overflow shows all LEDs steadily on. No prescaler logic is present.

Decomposition:
- Shared package keypad_pkg holds:
  - MAX_DIGITS and LEN_W defaults.
  - Localparam LEN_OVERFLOW = MAX_DIGITS+1.
  - Typedef len_t = logic [LEN_W-1:0].
- One natural sub-module: rise_detect (history flop plus AND, with reset value 1). It is instantiated once for is_pressed.
- The decoder and LED thermometer stay as combinational logic in the top.

Test Plan:
- Reset with is_pressed held high, release reset, hold 3 cycles -> input_length stays 0, input_cs = 6'b000001, password_led = 0.
- Four press pulses (each 2 cycles high, 2 low), cs_en = 1 -> input_length 1,2,3,4, each update one cycle after the rising sample. Final input_cs = 6'b010000, password_led = 6'b001111.
- Eight press pulses -> input_length goes 6 then 7 and stays 7. input_cs = 0, password_led = 6'b111111 (blinks with the macro defined and BLINK_DIV = 2).
- is_star_pressed held high with two press pulses at length 3 -> input_length remains 3. After star is released, the next press gives 4.
- clear asserted in the same cycle as a press edge at length 5 -> input_length = 0 next cycle. Press held through the clear is not counted afterwards.
- cs_en = 0 at length 2 -> input_cs = 0. Asynchronous reset pulse mid-cycle at length 5 -> input_length = 0 immediately, without waiting for clk.
